// File: rtl/sevseg_scan_scheduler.sv
// 4-digit multiplexed 7-segment scanner with blanking gaps, per-frame value latching,
// leading-zero blanking and a timed override source B that preempts background source A.
module sevseg_scan_scheduler #(
  parameter int DIGIT_CYCLES = 131072,
  parameter int BLANK_CYCLES = 2500,
  parameter int HOLD_CYCLES  = 50000000,
  parameter bit LZB          = 1'b1
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic [15:0] value_a,
  input  logic        req_b,
  input  logic [15:0] value_b,
  output logic        ack_b,
  output logic        src_sel,
  output logic [3:0]  Anode_Activate,
  output logic [6:0]  LED_SEG
);

  localparam int SLOT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int SLOT_W   = $clog2(SLOT_MAX + 1);
  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);

  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
  localparam logic [SLOT_W-1:0] DIGIT_END = SLOT_W'(DIGIT_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [6:0]        SEG_OFF   = 7'b1111111;
  localparam logic [3:0]        ANODE_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK,
    ST_ON
  } scan_state_t;

  scan_state_t       state;
  logic [1:0]        digit;
  logic [SLOT_W-1:0] slot_cnt;
  logic [15:0]       frame_val;
  logic [15:0]       b_latch;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_active;
  logic              accept;
  logic [3:0]        nib;
  logic              lead_zero;
  logic [6:0]        seg_next;
  logic [3:0]        anode_next;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_OFF;
    endcase
  endfunction

  assign accept      = req_b && !ack_b;
  assign hold_active = (hold_cnt != '0);

  // A digit is a leading zero when it and everything to its left is zero; the last digit never is.
  always_comb begin
    nib       = frame_val[3:0];
    lead_zero = 1'b0;
    case (digit)
      2'd0: begin
        nib       = frame_val[15:12];
        lead_zero = (frame_val[15:12] == 4'h0);
      end
      2'd1: begin
        nib       = frame_val[11:8];
        lead_zero = (frame_val[15:8] == 8'h00);
      end
      2'd2: begin
        nib       = frame_val[7:4];
        lead_zero = (frame_val[15:4] == 12'h000);
      end
      default: begin
        nib       = frame_val[3:0];
        lead_zero = 1'b0;
      end
    endcase
    seg_next   = (LZB && lead_zero) ? SEG_OFF : seg_code(nib);
    anode_next = ~(4'b1000 >> digit);
  end

  // Slot counters start at 1 on entry so a phase lasts exactly its parameter;
  // the reset state counts from 0, giving the extra edge before the first lit digit.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state          <= ST_BLANK;
      digit          <= 2'd0;
      slot_cnt       <= '0;
      Anode_Activate <= ANODE_OFF;
      LED_SEG        <= SEG_OFF;
      src_sel        <= 1'b0;
      frame_val      <= value_a;
    end else begin
      case (state)
        ST_BLANK: begin
          if (slot_cnt == BLANK_END) begin
            state          <= ST_ON;
            slot_cnt       <= SLOT_ONE;
            Anode_Activate <= anode_next;
            LED_SEG        <= seg_next;
          end else begin
            slot_cnt <= slot_cnt + SLOT_ONE;
          end
        end
        ST_ON: begin
          if (slot_cnt == DIGIT_END) begin
            state          <= ST_BLANK;
            slot_cnt       <= SLOT_ONE;
            Anode_Activate <= ANODE_OFF;
            LED_SEG        <= SEG_OFF;
            digit          <= digit + 2'd1;
            // Leaving the last digit is the frame boundary: latch the owner's value once.
            if (digit == 2'd3) begin
              frame_val <= hold_active ? b_latch : value_a;
              src_sel   <= hold_active;
            end
          end else begin
            slot_cnt <= slot_cnt + SLOT_ONE;
          end
        end
        default: begin
          state          <= ST_BLANK;
          slot_cnt       <= '0;
          Anode_Activate <= ANODE_OFF;
          LED_SEG        <= SEG_OFF;
        end
      endcase
    end
  end

  // Override arbitration; a new accept restarts the hold and takes priority over expiry.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      ack_b    <= 1'b0;
      b_latch  <= 16'h0000;
      hold_cnt <= '0;
    end else begin
      ack_b <= accept;
      if (accept) begin
        b_latch  <= value_b;
        hold_cnt <= HOLD_LOAD;
      end else if (hold_active) begin
        hold_cnt <= hold_cnt - HOLD_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sevseg_scan_scheduler.sv
// Self-checking bench: a timing/arbitration model pushes expected lit digits to a scoreboard,
// popped whenever the DUT lights a new digit; all outputs are also compared every cycle.
module tb_sevseg_scan_scheduler;

  localparam int DIGIT = 8;
  localparam int BLANK = 2;
  localparam int HOLD  = 100;
  localparam int SLOT  = DIGIT + BLANK;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_a;
  logic        req_b;
  logic [15:0] value_b;
  logic        ack_b, src_sel;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        ack_b_n, src_sel_n;
  logic [3:0]  anode_n;
  logic [6:0]  seg_n;

  int total = 0;
  int bad   = 0;

  int          n;
  int          hold_m;
  logic [15:0] b_m;
  logic [15:0] frame_m;
  logic        ack_m;
  logic        src_m;
  logic [3:0]  anode_m;
  logic [6:0]  seg_m;
  logic [6:0]  seg0_m;
  logic [3:0]  prev_anode = 4'hF;
  logic [17:0] sb[$];

  always #5 clk = ~clk;

  sevseg_scan_scheduler #(
    .DIGIT_CYCLES(DIGIT), .BLANK_CYCLES(BLANK), .HOLD_CYCLES(HOLD), .LZB(1'b1)
  ) dut (
    .clock_50Mhz(clk), .reset(reset), .value_a(value_a), .req_b(req_b), .value_b(value_b),
    .ack_b(ack_b), .src_sel(src_sel), .Anode_Activate(anode), .LED_SEG(seg)
  );

  sevseg_scan_scheduler #(
    .DIGIT_CYCLES(DIGIT), .BLANK_CYCLES(BLANK), .HOLD_CYCLES(HOLD), .LZB(1'b0)
  ) dut_nolzb (
    .clock_50Mhz(clk), .reset(reset), .value_a(value_a), .req_b(req_b), .value_b(value_b),
    .ack_b(ack_b_n), .src_sel(src_sel_n), .Anode_Activate(anode_n), .LED_SEG(seg_n)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h at n=%0d", tag, got, exp, n);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input bit lzb);
    logic [3:0] nib;
    bit lead;
    lead = 1'b1;
    for (int i = 0; i <= d; i++)
      if (v[15-4*i -: 4] != 4'h0) lead = 1'b0;
    if (lzb && d < 3 && lead) return 7'b1111111;
    nib = v[15-4*d -: 4];
    case (nib)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Model: n counts edges since reset release; each digit slot is BLANK blank clocks then DIGIT lit.
  always @(posedge clk) begin
    int k;
    int d;
    logic acc;
    logic [17:0] e;
    if (reset) begin
      checkOutput("sb_drain", sb.size(), 0);
      sb.delete();
      n = 0; hold_m = 0; b_m = 16'h0; ack_m = 1'b0; src_m = 1'b0;
      frame_m = value_a; anode_m = 4'hF; seg_m = 7'h7F; seg0_m = 7'h7F;
    end else begin
      n++;
      k = n - 1;
      if (k % FRAME == 0 && k != 0) begin
        frame_m = (hold_m != 0) ? b_m : value_a;
        src_m   = (hold_m != 0);
      end
      acc   = req_b && !ack_m;
      ack_m = acc;
      if (acc) begin
        b_m = value_b;
        hold_m = HOLD;
      end else if (hold_m > 0) begin
        hold_m--;
      end
      if (k % SLOT < BLANK) begin
        anode_m = 4'hF; seg_m = 7'h7F; seg0_m = 7'h7F;
      end else begin
        d = (k % FRAME) / SLOT;
        anode_m = ~(4'b1000 >> d);
        seg_m   = exp_seg(frame_m, d, 1'b1);
        seg0_m  = exp_seg(frame_m, d, 1'b0);
        if (k % SLOT == BLANK) sb.push_back({anode_m, seg_m, seg0_m});
      end
    end
    #1;
    checkOutput("anode", anode, anode_m);
    checkOutput("seg", seg, seg_m);
    checkOutput("src_sel", src_sel, src_m);
    checkOutput("ack_b", ack_b, ack_m);
    checkOutput("anode_nolzb", anode_n, anode_m);
    checkOutput("seg_nolzb", seg_n, seg0_m);
    if (anode != 4'hF && prev_anode == 4'hF) begin
      checkOutput("sb_avail", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("sb_anode", anode, e[17:14]);
        checkOutput("sb_seg", seg, e[13:7]);
        checkOutput("sb_seg_nolzb", seg_n, e[6:0]);
      end
    end
    prev_anode = anode;
  end

  task automatic applyStimulus(input logic [15:0] a, input logic rq, input logic [15:0] b);
    @(negedge clk);
    value_a = a;
    req_b   = rq;
    value_b = b;
  endtask

  task automatic pulseReq(input logic [15:0] b);
    @(negedge clk);
    req_b   = 1'b1;
    value_b = b;
    @(negedge clk);
    req_b   = 1'b0;
  endtask

  task automatic runCycles(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic waitPhase(input int target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (n > 0 && (n - 1) % FRAME == target) found = 1'b1;
    end
    checkOutput("phase_reached", found, 1);
  endtask

  initial begin
    reset = 1'b1; value_a = 16'h1234; req_b = 1'b0; value_b = 16'h0;
    runCycles(5);
    reset = 1'b0;
    runCycles(2 * FRAME + 2);

    $display("[TB] leading zeros");
    applyStimulus(16'h0045, 1'b0, 16'h0);
    runCycles(2 * FRAME);
    applyStimulus(16'h0000, 1'b0, 16'h0);
    runCycles(2 * FRAME);

    $display("[TB] mid-frame source change");
    applyStimulus(16'h1111, 1'b0, 16'h0);
    runCycles(FRAME);
    waitPhase(15);
    value_a = 16'h2222;
    runCycles(FRAME + 20);

    $display("[TB] override hold and restart");
    pulseReq(16'h9876);
    runCycles(88);
    pulseReq(16'h0001);
    runCycles(98);
    pulseReq(16'h0302);
    runCycles(HOLD + 2 * FRAME + 10);

    $display("[TB] request held high");
    applyStimulus(16'h2222, 1'b1, 16'h4321);
    runCycles(9);
    applyStimulus(16'h2222, 1'b0, 16'h0);
    runCycles(HOLD + 2 * FRAME);

    $display("[TB] random values");
    for (int f = 0; f < 6; f++) begin
      applyStimulus(16'($urandom) >> (4 * $urandom_range(0, 3)), 1'b0, 16'h0);
      runCycles(FRAME);
    end

    $display("[TB] reset during digit 2 with hold active");
    applyStimulus(16'h0708, 1'b0, 16'h0);
    pulseReq(16'h5678);
    waitPhase(24);
    reset = 1'b1;
    runCycles(2);
    reset = 1'b0;
    runCycles(FRAME + 10);

    checkOutput("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
